// File: rtl/fft_spectrum_buffer_pkg.sv
// rtl/fft_spectrum_buffer_pkg.sv - shared constants, FSM encoding and counter helper
//
// Purpose: common definitions for the spectrum capture buffer.
//   SPEC_OUT_W  : stored bin height width
//   SPEC_BINS   : bins kept per frame
//   fsm_state_t : write-side capture FSM states
//   sat_inc16   : saturating +1 for the 16-bit event counters

package fft_spectrum_buffer_pkg;

  localparam int SPEC_OUT_W = 10;
  localparam int SPEC_BINS  = 512;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_COMMIT  = 2'd2,
    ST_PENDING = 2'd3
  } fsm_state_t;

  // Counters stick at all-ones instead of wrapping.
  function automatic logic [15:0] sat_inc16(input logic [15:0] value, input logic inc);
    if (inc && (value != 16'hFFFF)) begin
      return value + 16'd1;
    end
    return value;
  endfunction

endpackage

// File: rtl/fft_spectrum_buffer_spec_dpram.sv
// rtl/fft_spectrum_buffer_spec_dpram.sv - simple dual-port bin RAM with registered read
//
// Purpose: DEPTH x WIDTH memory, one write port and one registered read port.
// Ports:
//   clk_50m, rst_n     : clock, async active-low reset (read register only)
//   wr_en/wr_addr/wr_data : write port, written on the rising edge
//   rd_en/rd_addr      : read request, data appears on rd_data one cycle later
//   rd_data            : registered read data, holds when rd_en is low

module spec_dpram #(
  parameter int DEPTH = 1024,
  parameter int WIDTH = 10
) (
  input  logic                     clk_50m,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [WIDTH-1:0]         rd_data
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rd_data_q;
  logic [WIDTH-1:0] rd_data_d;

  // Array itself is not reset so it maps onto block RAM.
  always_ff @(posedge clk_50m) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  always_comb begin
    rd_data_d = rd_data_q;
    if (rd_en) begin
      rd_data_d = mem_q[rd_addr];
    end
  end

  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/fft_spectrum_buffer.sv
// rtl/fft_spectrum_buffer.sv - ping-pong FFT magnitude frame buffer for the spectrum renderer
//
// Purpose: capture one sop/eop delimited magnitude frame, scale each bin to
// display height and store it in the write bank; swap banks when the frame
// completes and the renderer is not holding the display bank.
// Ports:
//   clk_50m, rst_n      : clock, async active-low reset
//   mag_data/sop/eop/valid : incoming magnitude stream, no backpressure
//   rd_lock             : renderer is scanning the display bank, hold swaps
//   rd_en, rd_addr      : bin read request against the display bank
//   rd_data, rd_valid   : read response, one cycle after rd_en
//   frame_ready         : one-cycle pulse when a new display bank is live
//   drop_cnt            : frames ignored while a swap was waiting (saturating)
//   err_cnt             : malformed frames (saturating)

module fft_spectrum_buffer
  import fft_spectrum_buffer_pkg::*;
#(
  parameter int N_POINTS   = 1024,
  parameter int STORE_BINS = SPEC_BINS,
  parameter int MAG_W      = 32,
  parameter int OUT_W      = SPEC_OUT_W,
  parameter int SHIFT      = 12
) (
  input  logic                          clk_50m,
  input  logic                          rst_n,
  input  logic [MAG_W-1:0]              mag_data,
  input  logic                          mag_sop,
  input  logic                          mag_eop,
  input  logic                          mag_valid,
  input  logic                          rd_lock,
  input  logic                          rd_en,
  input  logic [$clog2(STORE_BINS)-1:0] rd_addr,
  output logic [OUT_W-1:0]              rd_data,
  output logic                          rd_valid,
  output logic                          frame_ready,
  output logic [15:0]                   drop_cnt,
  output logic [15:0]                   err_cnt
);

  localparam int BIN_W  = $clog2(STORE_BINS);
  // One extra bit so the counter can represent N_POINTS (overflow index).
  localparam int CNT_W  = $clog2(N_POINTS) + 1;
  localparam int RAM_DEPTH = 2 * STORE_BINS;

  localparam logic [MAG_W-1:0] SAT_LIM  = {{(MAG_W-OUT_W){1'b0}}, {OUT_W{1'b1}}};
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_POINTS - 1);
  localparam logic [CNT_W-1:0] CNT_END  = CNT_W'(N_POINTS);
  localparam logic [CNT_W-1:0] BIN_END  = CNT_W'(STORE_BINS);
  // A frame whose sop and eop share a beat is only complete when N_POINTS is 1.
  localparam logic ONE_BEAT_OK = (N_POINTS == 1);

  fsm_state_t       state_q, state_d;
  logic [CNT_W-1:0] bin_cnt_q, bin_cnt_d;
  logic             wr_bank_q, wr_bank_d;
  logic             frame_ready_q, frame_ready_d;
  logic             ready_late_q, ready_late_d;
  logic             rd_valid_q, rd_valid_d;
  logic [15:0]      drop_cnt_q, drop_cnt_d;
  logic [15:0]      err_cnt_q, err_cnt_d;

  logic [MAG_W-1:0] mag_shifted;
  logic [OUT_W-1:0] mag_scaled;
  logic             accepting;
  logic             swap_wait;
  logic             frame_start;
  logic             capture_beat;
  logic             cnt_ovf;
  logic             at_last;
  logic             wr_en;
  logic [BIN_W-1:0] wr_bin;
  logic             err_inc;
  logic             drop_inc;
  logic             swap_now;

  // Scaler: shift down to display range, clamp anything that still overflows.
  assign mag_shifted = mag_data >> SHIFT;
  assign mag_scaled  = (mag_shifted > SAT_LIM) ? {OUT_W{1'b1}} : mag_shifted[OUT_W-1:0];

  assign accepting    = (state_q == ST_IDLE) || (state_q == ST_CAPTURE);
  assign swap_wait    = (state_q == ST_COMMIT) || (state_q == ST_PENDING);
  assign frame_start  = mag_valid && mag_sop && accepting;
  assign capture_beat = mag_valid && !mag_sop && (state_q == ST_CAPTURE);
  // bin_cnt_q is the index of the beat currently on the input.
  assign cnt_ovf      = (bin_cnt_q >= CNT_END);
  assign at_last      = (bin_cnt_q == LAST_IDX);

  // State register
  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_CAPTURE: begin
        if (frame_start) begin
          // A sop always restarts, even mid-frame.
          if (mag_eop) begin
            state_d = ONE_BEAT_OK ? ST_COMMIT : ST_IDLE;
          end else begin
            state_d = ST_CAPTURE;
          end
        end else if (capture_beat) begin
          if (cnt_ovf) begin
            state_d = ST_IDLE;
          end else if (mag_eop) begin
            state_d = at_last ? ST_COMMIT : ST_IDLE;
          end
        end
      end
      ST_COMMIT: begin
        state_d = rd_lock ? ST_PENDING : ST_IDLE;
      end
      ST_PENDING: begin
        if (!rd_lock) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output and datapath logic
  always_comb begin
    wr_en     = 1'b0;
    wr_bin    = '0;
    bin_cnt_d = bin_cnt_q;
    err_inc   = 1'b0;

    if (frame_start) begin
      wr_en     = 1'b1;
      bin_cnt_d = CNT_W'(1);
      // Restarting mid-frame condemns the previous frame; a lone sop+eop beat
      // is itself malformed unless frames are one sample long.
      err_inc   = (state_q == ST_CAPTURE) || (mag_eop && !ONE_BEAT_OK);
    end else if (capture_beat) begin
      if (cnt_ovf) begin
        err_inc = 1'b1;
      end else begin
        wr_en     = (bin_cnt_q < BIN_END);
        wr_bin    = bin_cnt_q[BIN_W-1:0];
        bin_cnt_d = bin_cnt_q + CNT_W'(1);
        err_inc   = mag_eop && !at_last;
      end
    end

    if (state_d == ST_IDLE) begin
      bin_cnt_d = '0;
    end

    drop_inc  = mag_valid && mag_sop && swap_wait;
    swap_now  = swap_wait && !rd_lock;
    wr_bank_d = wr_bank_q ^ swap_now;

    // Immediate swaps from COMMIT announce together with the bank change;
    // a swap released from PENDING announces one cycle after it.
    frame_ready_d = ((state_q == ST_COMMIT) && !rd_lock) || ready_late_q;
    ready_late_d  = (state_q == ST_PENDING) && !rd_lock;

    drop_cnt_d = sat_inc16(drop_cnt_q, drop_inc);
    err_cnt_d  = sat_inc16(err_cnt_q, err_inc);
    rd_valid_d = rd_en;
  end

  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      bin_cnt_q     <= '0;
      wr_bank_q     <= 1'b0;
      frame_ready_q <= 1'b0;
      ready_late_q  <= 1'b0;
      rd_valid_q    <= 1'b0;
      drop_cnt_q    <= '0;
      err_cnt_q     <= '0;
    end else begin
      bin_cnt_q     <= bin_cnt_d;
      wr_bank_q     <= wr_bank_d;
      frame_ready_q <= frame_ready_d;
      ready_late_q  <= ready_late_d;
      rd_valid_q    <= rd_valid_d;
      drop_cnt_q    <= drop_cnt_d;
      err_cnt_q     <= err_cnt_d;
    end
  end

  // Writer owns wr_bank, renderer sees the other bank, so ports never collide.
  spec_dpram #(
    .DEPTH(RAM_DEPTH),
    .WIDTH(OUT_W)
  ) u_bins (
    .clk_50m (clk_50m),
    .rst_n   (rst_n),
    .wr_en   (wr_en),
    .wr_addr ({wr_bank_q, wr_bin}),
    .wr_data (mag_scaled),
    .rd_en   (rd_en),
    .rd_addr ({~wr_bank_q, rd_addr}),
    .rd_data (rd_data)
  );

  assign rd_valid    = rd_valid_q;
  assign frame_ready = frame_ready_q;
  assign drop_cnt    = drop_cnt_q;
  assign err_cnt     = err_cnt_q;

endmodule

// File: tb/tb_fft_spectrum_buffer.sv
// tb/tb_fft_spectrum_buffer.sv - self-checking bench for fft_spectrum_buffer

module tb_fft_spectrum_buffer;

  logic        clk_50m = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] mag_data = '0;
  logic        mag_sop = 1'b0;
  logic        mag_eop = 1'b0;
  logic        mag_valid = 1'b0;
  logic        rd_lock = 1'b0;
  logic        rd_en = 1'b0;
  logic [8:0]  rd_addr = '0;
  logic [9:0]  rd_data;
  logic        rd_valid;
  logic        frame_ready;
  logic [15:0] drop_cnt;
  logic [15:0] err_cnt;

  fft_spectrum_buffer dut (
    .clk_50m     (clk_50m),
    .rst_n       (rst_n),
    .mag_data    (mag_data),
    .mag_sop     (mag_sop),
    .mag_eop     (mag_eop),
    .mag_valid   (mag_valid),
    .rd_lock     (rd_lock),
    .rd_en       (rd_en),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .rd_valid    (rd_valid),
    .frame_ready (frame_ready),
    .drop_cnt    (drop_cnt),
    .err_cnt     (err_cnt)
  );

  always #10 clk_50m = ~clk_50m;

  typedef struct {
    logic [31:0] d;
    bit          sop;
    bit          eop;
  } beat_t;

  beat_t       beats[$];
  logic [31:0] fd[1024];
  int          exp_disp[512];
  int          held_disp[512];
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          fr_count = 0;
  int          fr_cyc = -1;
  int          eop_cyc = -1;

  always @(posedge clk_50m) cyc++;

  always @(negedge clk_50m) begin
    if (frame_ready === 1'b1) begin
      fr_count++;
      fr_cyc = cyc;
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference scaling: integer divide by 2^12, clamp to 10-bit full scale.
  function automatic int scale(input logic [31:0] m);
    int s;
    s = int'(m / 32'd4096);
    if (s > 1023) s = 1023;
    return s;
  endfunction

  task automatic tick();
    @(posedge clk_50m);
    #1;
  endtask

  task automatic push_frame();
    for (int k = 0; k < 1024; k++) beats.push_back('{fd[k], (k == 0), (k == 1023)});
  endtask

  task automatic fd_to_exp();
    for (int k = 0; k < 512; k++) exp_disp[k] = scale(fd[k]);
  endtask

  task automatic fd_random();
    for (int k = 0; k < 1024; k++) fd[k] = $urandom >> $urandom_range(0, 24);
  endtask

  task automatic send_beats(input int gap_pct);
    while (beats.size() > 0) begin
      beat_t b;
      b = beats.pop_front();
      for (int g = 0; g < 8 && int'($urandom_range(0, 99)) < gap_pct; g++) begin
        mag_valid = 1'b0;
        mag_sop   = 1'b0;
        mag_eop   = 1'b0;
        tick();
      end
      mag_valid = 1'b1;
      mag_sop   = b.sop;
      mag_eop   = b.eop;
      mag_data  = b.d;
      if (b.eop) eop_cyc = cyc;
      tick();
    end
    mag_valid = 1'b0;
    mag_sop   = 1'b0;
    mag_eop   = 1'b0;
    mag_data  = '0;
  endtask

  task automatic check_fr(input string tag, input int fr_before, input int exp_delta, input int exp_cyc);
    checks++;
    if (fr_count - fr_before != exp_delta) begin
      failures++;
      $display("FAIL %s frame_ready pulses: got %0d expected %0d", tag, fr_count - fr_before, exp_delta);
    end
    if (exp_delta == 1) begin
      checks++;
      if (fr_cyc != exp_cyc) begin
        failures++;
        $display("FAIL %s frame_ready cycle: got %0d expected %0d", tag, fr_cyc, exp_cyc);
      end
    end
  endtask

  task automatic check_cnt(input string tag, input logic [15:0] got, input int expv);
    checks++;
    if (got !== 16'(expv)) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, expv);
    end
  endtask

  // Sequential pipelined read of every bin against the expected display.
  task automatic check_display(input string tag);
    rd_en   = 1'b1;
    rd_addr = '0;
    for (int a = 0; a < 512; a++) begin
      tick();
      checks++;
      if (rd_valid !== 1'b1 || rd_data !== 10'(exp_disp[a])) begin
        failures++;
        $display("FAIL %s bin %0d: rd_valid=%0b rd_data=%0d expected rd_valid=1 rd_data=%0d",
                 tag, a, rd_valid, rd_data, exp_disp[a]);
      end
      if (a < 511) rd_addr = 9'(a + 1);
      else rd_en = 1'b0;
    end
    tick();
    checks++;
    if (rd_valid !== 1'b0) begin
      failures++;
      $display("FAIL %s rd_valid after stop: got %0b expected 0", tag, rd_valid);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    checks++; if (rd_data !== 10'd0) begin failures++; $display("FAIL reset rd_data: got %0d expected 0", rd_data); end
    checks++; if (rd_valid !== 1'b0) begin failures++; $display("FAIL reset rd_valid: got %0b expected 0", rd_valid); end
    checks++; if (frame_ready !== 1'b0) begin failures++; $display("FAIL reset frame_ready: got %0b expected 0", frame_ready); end
    check_cnt("reset drop_cnt", drop_cnt, 0);
    check_cnt("reset err_cnt", err_cnt, 0);
  endtask

  task automatic test_clean_frame();
    int fr0;
    fr0 = fr_count;
    for (int k = 0; k < 1024; k++) fd[k] = 32'(k) << 12;
    push_frame();
    send_beats(0);
    repeat (4) tick();
    check_fr("clean", fr0, 1, eop_cyc + 2);
    fd_to_exp();
    check_display("clean");
    check_cnt("clean err_cnt", err_cnt, 0);
  endtask

  task automatic test_saturation();
    int fr0;
    fr0 = fr_count;
    for (int k = 0; k < 1024; k++) fd[k] = 32'hFFFF_FFFF;
    push_frame();
    send_beats(0);
    repeat (4) tick();
    check_fr("sat_full", fr0, 1, eop_cyc + 2);
    fd_to_exp();
    check_display("sat_full");

    fr0 = fr_count;
    fd_random();
    fd[10] = 32'h003F_F000;
    fd[11] = 32'h003F_E000;
    fd[12] = 32'h003F_FFFF;
    fd[13] = 32'h0040_0000;
    push_frame();
    send_beats(0);
    repeat (4) tick();
    check_fr("sat_mix", fr0, 1, eop_cyc + 2);
    fd_to_exp();
    check_display("sat_mix");
  endtask

  task automatic test_swap_hold();
    int fr0;
    int lcyc;
    int a;
    rd_lock = 1'b1;
    tick();
    fr0 = fr_count;
    fd_random();
    for (int k = 0; k < 512; k++) held_disp[k] = scale(fd[k]);
    push_frame();
    send_beats(0);
    repeat (6) tick();
    check_fr("hold_locked", fr0, 0, 0);
    check_display("hold_old_bank");

    fd_random();
    push_frame();
    send_beats(0);
    repeat (2) tick();
    check_cnt("hold drop_cnt", drop_cnt, 1);
    check_cnt("hold err_cnt", err_cnt, 0);
    check_fr("hold_dropped", fr0, 0, 0);

    // Release lock while a read is in flight: that read still sees the old bank.
    a = int'($urandom_range(0, 511));
    rd_lock = 1'b0;
    rd_en   = 1'b1;
    rd_addr = 9'(a);
    lcyc    = cyc;
    tick();
    checks++;
    if (rd_data !== 10'(exp_disp[a])) begin
      failures++;
      $display("FAIL swap_edge_old bin %0d: got %0d expected %0d", a, rd_data, exp_disp[a]);
    end
    tick();
    rd_en = 1'b0;
    checks++;
    if (rd_data !== 10'(held_disp[a])) begin
      failures++;
      $display("FAIL swap_edge_new bin %0d: got %0d expected %0d", a, rd_data, held_disp[a]);
    end
    repeat (3) tick();
    check_fr("hold_release", fr0, 1, lcyc + 2);
    for (int k = 0; k < 512; k++) exp_disp[k] = held_disp[k];
    check_display("hold_new_bank");
  endtask

  task automatic test_malformed();
    int fr0;
    fr0 = fr_count;
    for (int k = 0; k <= 100; k++) beats.push_back('{$urandom, (k == 0), (k == 100)});
    send_beats(0);
    repeat (4) tick();
    check_cnt("early_eop err_cnt", err_cnt, 1);
    check_fr("early_eop", fr0, 0, 0);

    fr0 = fr_count;
    for (int k = 0; k < 300; k++) beats.push_back('{$urandom, (k == 0), 1'b0});
    fd_random();
    push_frame();
    send_beats(0);
    repeat (4) tick();
    check_cnt("restart err_cnt", err_cnt, 2);
    check_fr("restart", fr0, 1, eop_cyc + 2);
    fd_to_exp();
    check_display("restart");

    fr0 = fr_count;
    for (int k = 0; k < 1025; k++) beats.push_back('{$urandom, (k == 0), 1'b0});
    send_beats(0);
    repeat (4) tick();
    check_cnt("overflow err_cnt", err_cnt, 3);
    check_fr("overflow", fr0, 0, 0);

    beats.push_back('{32'h0012_3000, 1'b1, 1'b1});
    send_beats(0);
    repeat (4) tick();
    check_cnt("single_beat err_cnt", err_cnt, 4);
    check_fr("single_beat", fr0, 0, 0);
    check_display("after_errors");
  endtask

  task automatic test_gapped();
    int fr0;
    fr0 = fr_count;
    for (int k = 0; k < 1024; k++) fd[k] = 32'(k) << 12;
    push_frame();
    send_beats(50);
    repeat (4) tick();
    check_fr("gapped", fr0, 1, eop_cyc + 2);
    fd_to_exp();
    check_display("gapped");
    check_cnt("gapped err_cnt", err_cnt, 4);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 200; i++) begin
      bit en;
      int a;
      en = ($urandom_range(0, 3) != 0);
      a  = int'($urandom_range(0, 511));
      rd_en   = en;
      rd_addr = 9'(a);
      tick();
      checks++;
      if (rd_valid !== en) begin
        failures++;
        $display("FAIL b2b rd_valid step %0d: got %0b expected %0b", i, rd_valid, en);
      end
      if (en) begin
        checks++;
        if (rd_data !== 10'(exp_disp[a])) begin
          failures++;
          $display("FAIL b2b rd_data bin %0d: got %0d expected %0d", a, rd_data, exp_disp[a]);
        end
      end
    end
    rd_en = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    int fr0;
    for (int k = 0; k < 400; k++) beats.push_back('{$urandom, (k == 0), 1'b0});
    send_beats(0);
    #4;
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    check_cnt("mid_reset err_cnt", err_cnt, 0);
    check_cnt("mid_reset drop_cnt", drop_cnt, 0);
    checks++; if (rd_valid !== 1'b0 || rd_data !== 10'd0 || frame_ready !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset outputs: rd_valid=%0b rd_data=%0d frame_ready=%0b expected 0 0 0",
               rd_valid, rd_data, frame_ready);
    end
    fr0 = fr_count;
    fd_random();
    push_frame();
    send_beats(0);
    repeat (4) tick();
    check_fr("mid_reset_frame", fr0, 1, eop_cyc + 2);
    fd_to_exp();
    check_display("mid_reset_frame");
    check_cnt("mid_reset final err_cnt", err_cnt, 0);
  endtask

  initial begin
    test_reset();
    test_clean_frame();
    test_saturation();
    test_swap_hold();
    test_malformed();
    test_gapped();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
